// File: rtl/param_fifo_pkg.sv
// param_fifo_pkg: shared defaults and a portable clog2 for the parametrised FIFO.
package param_fifo_pkg;
  localparam int FIFO_DEF_WIDTH = 32;
  localparam int FIFO_DEF_DEPTH = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: AW+1 bit wrap-flag pointer with increment enable, sync and async clear.
module fifo_ptr #(
  parameter int AW = 4
) (
  input  logic        clock_i,
  input  logic        aclr_i,
  input  logic        sclr_i,
  input  logic        inc_i,
  output logic [AW:0] ptr_o
);
  logic [AW:0] ptr_q, ptr_d;
  always_comb ptr_d = sclr_i ? '0 : ptr_q + (AW+1)'(inc_i);
  always_ff @(posedge clock_i or posedge aclr_i)
    if (aclr_i) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/param_fifo.sv
// param_fifo: show-ahead single-clock FIFO with level flags; PARAM_FIFO_ERR_FLAGS_EN adds
// sticky overflow/underflow outputs.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEF_WIDTH,
  parameter int DEPTH    = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             sclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      usedw
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);
  localparam logic [AW:0] FULL_T = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_T   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_T   = (AW+1)'(AE_LEVEL);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp, rp;
  logic             we, re;
  assign we = wrreq && !full && !sclr;
  assign re = rdreq && !empty && !sclr;
  fifo_ptr #(.AW(AW)) u_wp (.clock_i(clock), .aclr_i(aclr), .sclr_i(sclr), .inc_i(we), .ptr_o(wp));
  fifo_ptr #(.AW(AW)) u_rp (.clock_i(clock), .aclr_i(aclr), .sclr_i(sclr), .inc_i(re), .ptr_o(rp));
  always_ff @(posedge clock)
    if (we) mem_q[wp[AW-1:0]] <= data;
  // Modulo subtraction; the wrap MSB separates full from empty.
  assign usedw        = wp - rp;
  assign full         = usedw == FULL_T;
  assign empty        = usedw == '0;
  assign almost_full  = usedw >= AF_T;
  assign almost_empty = usedw <= AE_T;
  assign q            = mem_q[rp[AW-1:0]];
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  always_comb begin
    overflow_d  = sclr ? 1'b0 : overflow_q | (wrreq && full);
    underflow_d = sclr ? 1'b0 : underflow_q | (rdreq && empty);
  end
  always_ff @(posedge clock or posedge aclr)
    if (aclr) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: randomized and directed checks of param_fifo against a queue reference model.
module tb_param_fifo;
  logic        clock = 0, aclr = 1, sclr = 0, wrreq = 0, rdreq = 0;
  logic [31:0] data = '0, q;
  logic        full, empty, almost_full, almost_empty;
  logic [4:0]  usedw;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic        overflow, underflow;
`endif
  int          total = 0, bad = 0;
  logic [31:0] m [$];
  logic        ov_m = 0, un_m = 0;

  param_fifo dut (
    .clock(clock), .aclr(aclr), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .usedw(usedw)
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = m.size();
    chk("usedw", 32'(usedw), n);
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 16));
    chk("almost_full", 32'(almost_full), 32'(n >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    if (n > 0) chk("q", q, m[0]);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    chk("overflow", 32'(overflow), 32'(ov_m));
    chk("underflow", 32'(underflow), 32'(un_m));
`endif
  endtask

  task automatic step(input logic w, input logic r, input logic [31:0] d, input logic s);
    int n;
    wrreq = w; rdreq = r; data = d; sclr = s;
    @(posedge clock);
    n = m.size();
    if (s) begin
      m.delete(); ov_m = 0; un_m = 0;
    end else begin
      if (w && n == 16) ov_m = 1;
      if (r && n == 0) un_m = 1;
      if (r && n > 0) void'(m.pop_front());
      if (w && n < 16) m.push_back(d);
    end
    #1;
    wrreq = 0; rdreq = 0; sclr = 0;
    check_all();
  endtask

  initial begin
    int acc;
    #1 check_all();
    #12 aclr = 0;
    @(negedge clock);
    for (int i = 0; i < 5; i++) step(1, 0, $urandom, 0);
    #2 aclr = 1;
    #1 m.delete(); ov_m = 0; un_m = 0;
    check_all();
    #1 aclr = 0;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    ov_m = 0; un_m = 0;
    step(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 32'h1000 + i, 0);
    chk("fill_full", 32'(full), 1);
    step(1, 0, 32'hDEAD, 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", q, 32'h1000 + i);
      step(0, 1, 0, 0);
    end
    step(1, 0, 32'hA5A5A5A5, 0);
    chk("show_ahead", q, 32'hA5A5A5A5);
    step(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, $urandom, 0);
    for (int i = 0; i < 10; i++) step(1, 1, $urandom, 0);
    chk("simul_7", 32'(usedw), 7);
    for (int i = 0; i < 9; i++) step(1, 0, $urandom, 0);
    step(1, 1, 32'hBEEF, 0);
    chk("simul_full", 32'(usedw), 15);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0);
    step(1, 1, 32'hC0DE, 0);
    chk("simul_empty", 32'(usedw), 1);
    step(0, 1, 0, 0);
    acc = 0;
    for (int i = 0; i < 400 && acc < 40; i++) begin
      logic w, r;
      w = (m.size() < 3) && $urandom_range(0, 1) == 1;
      r = (m.size() > 0) && $urandom_range(0, 1) == 1;
      if (w) acc++;
      step(w, r, $urandom, 0);
    end
    chk("wrap_budget", 32'(acc >= 40), 1);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 40) == 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, $urandom, 0);
    step(1, 0, 32'h5555, 0);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    chk("overflow_set", 32'(overflow), 1);
    chk("underflow_set", 32'(underflow), 1);
`endif
    step(1, 0, 32'h7777, 1);
    chk("sclr_usedw", 32'(usedw), 0);
    step(0, 1, 0, 0);
    chk("sclr_discard", 32'(empty), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
